seq_divider_unit: RTL and testbench

//  Multi-cycle shift-subtract divider for the KGP_RISC ALU. It is the inverse

---
 rtl/seq_divider_unit.sv | 155 +++++++++++++++
 tb/tb_seq_divider_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_unit.sv
// Multi-cycle restoring shift-subtract divider (signed/unsigned) for the ALU.
// One quotient bit per cycle; magnitudes are divided and signs fixed up at the end.
module seq_divider_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] d_q, d_d;        // divisor magnitude
  logic [WIDTH-1:0] r_q, r_d;        // partial remainder
  logic [WIDTH-1:0] q_q, q_d;        // dividend bits shifting out / quotient bits shifting in
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted_r;       // partial remainder with next dividend bit appended
  logic [WIDTH+1:0] trial;           // trial subtraction; MSB is the borrow
  logic             borrow;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  // Next-state, datapath step and output register inputs
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    d_d      = d_q;
    r_d      = r_q;
    q_d      = q_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    zero_d   = zero_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;

    shifted_r    = {r_q, q_q[WIDTH-1]};
    trial        = {1'b0, shifted_r} - {2'b00, d_q};
    borrow       = trial[WIDTH+1];
    dividend_mag = (is_signed && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
    divisor_mag  = (is_signed && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_q_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_d = is_signed & dividend[WIDTH-1];
          d_d     = divisor_mag;
          r_d     = '0;
          count_d = CW'(WIDTH);
          zero_d  = (divisor == '0);
          if (divisor == '0) begin
            // Keep the raw dividend; it is reported unmodified as the remainder
            q_d     = dividend;
            state_d = S_DONE;
          end else begin
            q_d     = dividend_mag;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        q_d     = {q_q[WIDTH-2:0], ~borrow};
        r_d     = borrow ? shifted_r[WIDTH-1:0] : trial[WIDTH-1:0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quot_d  = neg_q_q ? (WIDTH'(0) - q_q) : q_q;
        rem_d   = neg_r_q ? (WIDTH'(0) - r_q) : r_q;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (zero_q) begin
          quot_d = '1;
          rem_d  = q_q;
          dbz_d  = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      d_q     <= d_d;
      r_q     <= r_d;
      q_q     <= q_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_unit.sv
// Scoreboard bench for seq_divider_unit: driver pushes expected results from a
// plain-arithmetic model, a negedge monitor pops and compares on each done pulse.
module tb_seq_divider_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int unsigned  at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned dones = 0;
  int unsigned ops = 0;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Truncating division: quotient rounds toward zero, remainder takes dividend sign
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sbv, qq, rr;
    e.at = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      qq  = sa / sbv;
      rr  = sa % sbv;
      e.q = qq[W-1:0]; e.r = rr[W-1:0]; e.dbz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare every done pulse against the oldest expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      dones++;
      chk("done_single_pulse", 64'(prev_done), 64'd0);
      chk("busy_done_exclusive", 64'(busy), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(mon_e.q));
        chk("remainder", 64'(remainder), 64'(mon_e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
        chk("done_latency", 64'(cyc), 64'(mon_e.at));
      end
    end
    prev_done = done;
  end

  // Issue one operation; optionally pulse a foreign start 'inject' cycles into it
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int inject);
    exp_t e;
    int   n;
    @(negedge clk);
    e    = model(a, b, s);
    e.at = cyc + 1 + ((b == '0) ? 1 : W + 2);
    sb.push_back(e);
    ops++;
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    chk("busy_after_accept", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < int'(W) + 8) begin
      start = (n == inject);
      if (n == inject) begin
        dividend = 32'd999; divisor = 32'd2; is_signed = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           sel;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    // Directed cases
    run_op(32'd100, 32'd7, 1'b0, -1);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, -1);          // -100 / 7
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, -1);        // 100 / -7
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, -1);  // -100 / -7
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);  // signed overflow
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    run_op(32'h0000_1234, 32'd0, 1'b0, -1);
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, -1);          // -5 / 0 keeps raw dividend
    run_op(32'd0, 32'd9, 1'b1, -1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1);
    run_op(32'd1000, 32'd3, 1'b0, 5);                // start mid-RUN ignored
    run_op(32'd77, 32'd8, 1'b0, -1);                 // back-to-back
    run_op(32'd7, 32'd100, 1'b1, -1);

    // Reset at cycle 10 of RUN discards the operation
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    chk("midrst_remainder", 64'(remainder), 64'd0);
    chk("midrst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("midrst_no_done_quotient", 64'(quotient), 64'd0);
    run_op(32'd50, 32'd5, 1'b0, -1);

    // Randomized pairs
    for (int i = 0; i < 1500; i++) begin
      s   = 1'($urandom);
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = '1;
        3:       begin a = 32'h8000_0000; b = $urandom; end
        4:       b = $urandom >> $urandom_range(1, 31);
        default: b = $urandom;
      endcase
      run_op(a, b, s, (sel == 5) ? $urandom_range(0, 20) : -1);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("done_count", 64'(dones), 64'(ops));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
